sv8000_keypad: RTL and testbench

Keypad/joystick input stage for the Super Vision 8000 core. Turns MiSTer `ps2_key` events and the two joystick words into the 3-row × 8-bit active-low key matrix. Answers the PPI's column select with registered port-B (`keydata`) and port-A (`joydata`) bytes. Sits directly upstream of the i8255 and replaces the ad-hoc keyboard latches in the system top.

---
 rtl/sv8000_pkg.sv | 64 ++++++
 rtl/sv8000_key_latch.sv | 56 +++++
 rtl/sv8000_keypad.sv | 63 ++++++
 tb/tb_sv8000_keypad.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sv8000_pkg.sv
// Shared constants for the Super Vision 8000 keypad stage: button indices,
// the scancode alias table and where each button sits in the key matrix.
package sv8000_pkg;

  localparam int NUM_BTNS = 24;
  localparam int NUM_SIDE = 12;
  localparam int NUM_KEYS = 36;

  // Per side: digits 1..9, then 0, * (A) and # (H).
  typedef enum logic [4:0] {
    BTN_L1, BTN_L2, BTN_L3, BTN_L4, BTN_L5, BTN_L6,
    BTN_L7, BTN_L8, BTN_L9, BTN_L0, BTN_LA, BTN_LH,
    BTN_R1, BTN_R2, BTN_R3, BTN_R4, BTN_R5, BTN_R6,
    BTN_R7, BTN_R8, BTN_R9, BTN_R0, BTN_RA, BTN_RH
  } button_e;

  // One entry per physical PS/2 key; bit 8 marks an E0-prefixed code.
  localparam logic [8:0] KEY_CODE [NUM_KEYS] = '{
    9'h016, 9'h01E, 9'h026,
    9'h015, 9'h025, 9'h01D, 9'h02E, 9'h024, 9'h036,
    9'h01C, 9'h03D, 9'h01B, 9'h03E, 9'h023, 9'h046,
    9'h022, 9'h045, 9'h01A, 9'h04E, 9'h021, 9'h055,
    9'h069, 9'h072, 9'h07A, 9'h06B, 9'h073, 9'h074,
    9'h06C, 9'h075, 9'h07D, 9'h070,
    9'h07C, 9'h071, 9'h07B, 9'h05A, 9'h15A
  };

  localparam button_e KEY_BTN [NUM_KEYS] = '{
    BTN_L1, BTN_L2, BTN_L3,
    BTN_L4, BTN_L4, BTN_L5, BTN_L5, BTN_L6, BTN_L6,
    BTN_L7, BTN_L7, BTN_L8, BTN_L8, BTN_L9, BTN_L9,
    BTN_L0, BTN_L0, BTN_LA, BTN_LA, BTN_LH, BTN_LH,
    BTN_R1, BTN_R2, BTN_R3, BTN_R4, BTN_R5, BTN_R6,
    BTN_R7, BTN_R8, BTN_R9, BTN_R0,
    BTN_RA, BTN_RA, BTN_RH, BTN_RH, BTN_RH
  };

  // Matrix row and bit (MSB = 7) of each button, in button_e order.
  localparam logic [1:0] BTN_ROW [NUM_BTNS] = '{
    2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2,
    2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2
  };

  localparam logic [2:0] BTN_BIT [NUM_BTNS] = '{
    3'd7, 3'd7, 3'd7, 3'd6, 3'd6, 3'd6, 3'd5, 3'd5, 3'd5, 3'd4, 3'd4, 3'd4,
    3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0
  };

  // Position inside the 24-bit {row2,row1,row0} matrix word.
  function automatic logic [4:0] btn_pos(input logic [4:0] b);
    return {BTN_ROW[b], BTN_BIT[b]};
  endfunction

  // Joystick word to per-side button presses, in button_e side order.
  function automatic logic [NUM_SIDE-1:0] joy_keys(input logic [17:0] joy);
    logic [NUM_SIDE-1:0] keys;
    for (int d = 0; d < 9; d++) keys[d] = joy[6+d];
    keys[9]  = joy[15];
    keys[10] = joy[4] | joy[16];
    keys[11] = joy[5] | joy[17];
    return keys;
  endfunction

endpackage

// File: rtl/sv8000_key_latch.sv
// PS/2 event decoder: toggle edge detect, per-physical-key held flags and
// the registered active-low keyboard-only matrix.
module sv8000_key_latch
  import sv8000_pkg::*;
#(
  parameter bit EXT_NUMPAD = 1'b1
) (
  input  logic        clk_3m58,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic [23:0] key_state
);

  logic                tog_q;
  logic                key_event;
  logic [NUM_KEYS-1:0] held;
  logic [NUM_KEYS-1:0] held_next;
  logic [NUM_BTNS-1:0] btn_down;
  logic [23:0]         key_state_next;

  assign key_event = ps2_key[10] ^ tog_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    held_next = held;
    if (key_event) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        // E0 codes only match when they are explicitly in the table and enabled.
        if (ps2_key[8:0] == KEY_CODE[i] && (!KEY_CODE[i][8] || EXT_NUMPAD))
          held_next[i] = ps2_key[9];
      end
    end
  end

  always_comb begin
    btn_down = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (held_next[i]) btn_down[KEY_BTN[i]] = 1'b1;
    key_state_next = '1;
    for (int b = 0; b < NUM_BTNS; b++)
      key_state_next[btn_pos(5'(b))] = ~btn_down[b];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_3m58) begin
    tog_q <= ps2_key[10];
    if (reset) begin
      held      <= '0;
      key_state <= '1;
    end else begin
      held      <= held_next;
      key_state <= key_state_next;
    end
  end

endmodule

// File: rtl/sv8000_keypad.sv
// Keypad/joystick input stage: merges joystick buttons into the key matrix
// and answers the PPI column select with registered port A/B bytes.
module sv8000_keypad
  import sv8000_pkg::*;
#(
  parameter bit EXT_NUMPAD = 1'b1
) (
  input  logic        clk_3m58,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [31:0] joy0,
  input  logic [31:0] joy1,
  input  logic [2:0]  key_column,
  output logic [7:0]  keydata,
  output logic [7:0]  joydata,
  output logic [23:0] key_state
);

  logic [NUM_SIDE-1:0] joy_left;
  logic [NUM_SIDE-1:0] joy_right;
  logic [23:0]         merged;
  logic [7:0]          keydata_next;
  logic [7:0]          joydata_next;
  logic                unused_joy;

  sv8000_key_latch #(
    .EXT_NUMPAD(EXT_NUMPAD)
  ) u_key_latch (
    .clk_3m58  (clk_3m58),
    .reset     (reset),
    .ps2_key   (ps2_key),
    .key_state (key_state)
  );

  // joy1 drives the left controller, joy0 the right.
  assign joy_left   = joy_keys(joy1[17:0]);
  assign joy_right  = joy_keys(joy0[17:0]);
  assign unused_joy = ^{joy0[31:18], joy1[31:18]};

  always_comb begin
    merged = key_state;
    for (int k = 0; k < NUM_SIDE; k++) begin
      if (joy_left[k])  merged[btn_pos(5'(k))]            = 1'b0;
      if (joy_right[k]) merged[btn_pos(5'(k + NUM_SIDE))] = 1'b0;
    end
    keydata_next = '1;
    for (int r = 0; r < 3; r++)
      if (!key_column[r]) keydata_next &= merged[r*8 +: 8];
    joydata_next = ~{joy1[0], joy1[1], joy1[2], joy1[3],
                     joy0[0], joy0[1], joy0[2], joy0[3]};
  end

  always_ff @(posedge clk_3m58) begin
    if (reset) begin
      keydata <= '1;
      joydata <= '1;
    end else begin
      keydata <= keydata_next;
      joydata <= joydata_next;
    end
  end

endmodule

// File: tb/tb_sv8000_keypad.sv
// Scoreboard bench for sv8000_keypad: one instance with the E0 keypad Enter
// enabled and one without, both checked against a keypad-layout model.
module tb_sv8000_keypad;

  logic        clk_3m58 = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [31:0] joy0, joy1;
  logic [2:0]  key_column;
  logic [7:0]  kd1, jd1, kd0, jd0;
  logic [23:0] ks1, ks0;

  always #10 clk_3m58 = ~clk_3m58;

  sv8000_keypad #(.EXT_NUMPAD(1'b1)) u_dut (
    .clk_3m58(clk_3m58), .reset(reset), .ps2_key(ps2_key), .joy0(joy0), .joy1(joy1),
    .key_column(key_column), .keydata(kd1), .joydata(jd1), .key_state(ks1)
  );

  sv8000_keypad #(.EXT_NUMPAD(1'b0)) u_dut_nx (
    .clk_3m58(clk_3m58), .reset(reset), .ps2_key(ps2_key), .joy0(joy0), .joy1(joy1),
    .key_column(key_column), .keydata(kd0), .joydata(jd0), .key_state(ks0)
  );

  typedef struct {
    logic [7:0]  kd1, kd0, jd;
    logic [23:0] ks1, ks0;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Aliases per keypad label: index 0..9 = digit, 10 = '*', 11 = '#'.
  int left_al [12][2] = '{
    '{'h22, 'h45}, '{'h16, -1}, '{'h1E, -1}, '{'h26, -1},
    '{'h15, 'h25}, '{'h1D, 'h2E}, '{'h24, 'h36}, '{'h1C, 'h3D},
    '{'h1B, 'h3E}, '{'h23, 'h46}, '{'h1A, 'h4E}, '{'h21, 'h55}
  };
  int right_al [12][3] = '{
    '{'h70, -1, -1}, '{'h69, -1, -1}, '{'h72, -1, -1}, '{'h7A, -1, -1},
    '{'h6B, -1, -1}, '{'h73, -1, -1}, '{'h74, -1, -1}, '{'h6C, -1, -1},
    '{'h75, -1, -1}, '{'h7D, -1, -1}, '{'h7C, 'h71, -1}, '{'h7B, 'h5A, 'h15A}
  };
  // Matrix row r holds keypad column {1,4,7,*}, {2,5,8,0}, {3,6,9,#}.
  int layout [3][4] = '{'{1, 4, 7, 10}, '{2, 5, 8, 0}, '{3, 6, 9, 11}};

  bit   held [512];
  logic tog_m;
  int   pool[$];

  function automatic bit side_down(input bit right, input int label, input bit ext);
    if (!right) begin
      for (int a = 0; a < 2; a++)
        if (left_al[label][a] >= 0 && held[left_al[label][a]]) return 1'b1;
    end else begin
      for (int a = 0; a < 3; a++) begin
        int code = right_al[label][a];
        if (code >= 0 && !(code == 'h15A && !ext) && held[code]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [23:0] ks_of(input bit ext);
    logic [23:0] ks = '1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        ks[r*8 + 7 - c] = ~side_down(1'b0, layout[r][c], ext);
        ks[r*8 + 3 - c] = ~side_down(1'b1, layout[r][c], ext);
      end
    return ks;
  endfunction

  function automatic bit joy_down(input logic [31:0] j, input int label);
    case (label)
      0:       return j[15];
      10:      return j[4] | j[16];
      11:      return j[5] | j[17];
      default: return j[5 + label];
    endcase
  endfunction

  function automatic logic [7:0] kd_of(input bit ext);
    logic [23:0] m = ks_of(ext);
    logic [7:0]  kd = '1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        if (joy_down(joy1, layout[r][c])) m[r*8 + 7 - c] = 1'b0;
        if (joy_down(joy0, layout[r][c])) m[r*8 + 3 - c] = 1'b0;
      end
    for (int r = 0; r < 3; r++)
      if (!key_column[r]) kd &= m[r*8 +: 8];
    return kd;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predict the outputs after the coming edge from the current inputs, then advance one clock.
  task automatic cycle();
    exp_t e;
    if (reset) begin
      e.kd1 = 8'hFF; e.kd0 = 8'hFF; e.jd = 8'hFF;
      e.ks1 = 24'hFFFFFF; e.ks0 = 24'hFFFFFF;
      foreach (held[i]) held[i] = 1'b0;
    end else begin
      e.kd1 = kd_of(1'b1);
      e.kd0 = kd_of(1'b0);
      e.jd  = ~{joy1[0], joy1[1], joy1[2], joy1[3], joy0[0], joy0[1], joy0[2], joy0[3]};
      if (ps2_key[10] != tog_m) held[ps2_key[8:0]] = ps2_key[9];
      e.ks1 = ks_of(1'b1);
      e.ks0 = ks_of(1'b0);
    end
    tog_m = ps2_key[10];
    sb.push_back(e);
    @(posedge clk_3m58);
    #2;
  endtask

  task automatic send(input bit pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
    cycle();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_3m58);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("keydata", {24'd0, kd1}, {24'd0, e.kd1});
        check("keydata_nx", {24'd0, kd0}, {24'd0, e.kd0});
        check("joydata", {24'd0, jd1}, {24'd0, e.jd});
        check("joydata_nx", {24'd0, jd0}, {24'd0, e.jd});
        check("key_state", {8'd0, ks1}, {8'd0, e.ks1});
        check("key_state_nx", {8'd0, ks0}, {8'd0, e.ks0});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    for (int l = 0; l < 12; l++) begin
      for (int a = 0; a < 2; a++) if (left_al[l][a] >= 0) pool.push_back(left_al[l][a]);
      for (int a = 0; a < 3; a++) if (right_al[l][a] >= 0) pool.push_back(right_al[l][a]);
    end
    pool.push_back('h169); pool.push_back('h16B); pool.push_back('h170);
    pool.push_back('h175); pool.push_back('h17D); pool.push_back('h011);
    pool.push_back('h0F0); pool.push_back('h15A);

    // Reset with a high toggle bit: no event may fire once reset drops.
    reset = 1'b1; ps2_key = 11'h400; joy0 = '0; joy1 = '0; key_column = 3'b111;
    tog_m = 1'b0;
    repeat (5) cycle();
    reset = 1'b0;
    cycle(); cycle();
    check("post_reset_state", {8'd0, ks1}, 32'h00FFFFFF);

    key_column = 3'b110;
    send(1'b1, 9'h016); cycle();
    check("l1_row0", {24'd0, kd1}, 32'h7F);
    key_column = 3'b101; cycle();
    check("l1_row1", {24'd0, kd1}, 32'hFF);
    key_column = 3'b110;
    send(1'b0, 9'h016);

    // Two aliases of L4: releasing one keeps the button down.
    send(1'b1, 9'h015); send(1'b1, 9'h025); send(1'b0, 9'h015); cycle();
    check("l4_alias_held", {24'd0, kd1}, 32'hBF);
    send(1'b0, 9'h025); cycle();
    check("l4_released", {24'd0, kd1}, 32'hFF);

    // E0 69 (End) must not alias the numpad 1.
    send(1'b1, 9'h169); cycle();
    check("e0_end_ignored", {24'd0, kd1}, 32'hFF);
    send(1'b1, 9'h069); cycle();
    check("r1_row0", {24'd0, kd1}, 32'hF7);
    send(1'b0, 9'h069); send(1'b0, 9'h169);

    key_column = 3'b011;
    send(1'b1, 9'h15A); cycle();
    check("kp_enter_ext", {24'd0, kd1}, 32'hFE);
    check("kp_enter_noext", {24'd0, kd0}, 32'hFF);
    send(1'b0, 9'h15A);

    key_column = 3'b110;
    joy0 = 32'h10; cycle();
    check("joy0_star", {24'd0, kd1}, 32'hFE);
    joy0 = '0; joy1 = 32'h1; cycle();
    check("joy1_dir", {24'd0, jd1}, 32'h7F);
    joy1 = '0;

    // Reset while held: the later release is a no-op.
    send(1'b1, 9'h07C); cycle();
    reset = 1'b1; cycle();
    reset = 1'b0; send(1'b0, 9'h07C); cycle();
    check("reset_held_key", {8'd0, ks1}, 32'h00FFFFFF);

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 1) == 1)
        ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), 9'(pool[$urandom_range(0, pool.size() - 1)])};
      key_column = 3'($urandom);
      if ($urandom_range(0, 7) == 0) joy0 = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 7) == 0) joy1 = $urandom & $urandom & $urandom;
      reset = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0;
    cycle();

    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
